// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared encodings, FSM states and wait-counter width for the memory stage
package memory_access_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam int WAIT_W = 4;
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
   // Every funct3 that is not a byte or half access behaves as a word
   function automatic size_t accessSize(input logic [2:0] funct3);
      return (funct3 == F3_B || funct3 == F3_BU) ? SZ_B :
             (funct3 == F3_H || funct3 == F3_HU) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: req/ack data-memory bus between the memory stage and data memory
interface memory_access_if #(parameter int ADDR_WIDTH = 32);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic [31:0]           mem_rdata;
   logic                  mem_ack;
   logic                  mem_error;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_error,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_error,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/memory_access_lsu_align.sv
// lsu_align: byte-lane strobes/replicated store data and extended load data
module lsu_align
   import memory_access_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] loadData
);
   size_t       size;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic        uns;
   // Lane steering for stores and lane selection plus extension for loads
   always_comb begin
      size     = accessSize(funct3);
      uns      = funct3[2];
      lb       = rdata[{addr, 3'b000} +: 8];
      lh       = addr[1] ? rdata[31:16] : rdata[15:0];
      wstrb    = size == SZ_W ? 4'hF : size == SZ_H ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr;
      wdata    = size == SZ_W ? rs2 : size == SZ_H ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
      loadData = size == SZ_W ? rdata :
                 size == SZ_H ? {{16{lh[15] & ~uns}}, lh} : {{24{lb[7] & ~uns}}, lb};
   end
endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I memory stage; req/ack data access with stall. MEM_MISALIGN_TRAP_EN traps misaligned H/W.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_result,
   input  logic [31:0] in_rs2_value,
   input  logic [2:0]  in_funct3,
   input  logic        in_MemWrite,
   input  logic        in_MemRead,
   input  logic        in_RegWrite,
   input  logic        in_MemToReg,
   input  logic        in_RegDataSrc,
   input  logic        in_PCSrc,
   input  logic [4:0]  in_RegDest,
   output logic        stall,
   memory_access_if.master mem,
   output logic        out_RegWrite,
   output logic        out_MemToReg,
   output logic        out_RegDataSrc,
   output logic        out_PCSrc,
   output logic [4:0]  out_RegDest,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_mem_data
);
   state_t              state;
   logic [WAIT_W-1:0]   waitCnt;
   logic                memReq, memError, misalign, timeUp, isLoad;
   logic [31:0]         capResult, capRs2;
   logic [2:0]          capFunct3;
   logic                capMemWrite, capMemRead, capRegWrite, capMemToReg, capRegDataSrc, capPcSrc;
   logic [4:0]          capRegDest;
   logic [3:0]          wstrb;
   logic [31:0]         wdata, loadData;

`ifdef MEM_MISALIGN_TRAP_EN
   size_t inSize;
   assign inSize   = accessSize(in_funct3);
   assign misalign = (inSize == SZ_H && in_result[0]) || (inSize == SZ_W && in_result[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign timeUp         = waitCnt == WAIT_W'(TIMEOUT_CYCLES - 1);
   assign isLoad         = capMemRead & ~capMemWrite;
   assign mem.mem_req    = memReq;
   assign mem.mem_we     = memReq & capMemWrite;
   assign mem.mem_addr   = {capResult[ADDR_WIDTH-1:2], 2'b00};
   assign mem.mem_wdata  = wdata;
   assign mem.mem_wstrb  = (memReq & capMemWrite) ? wstrb : 4'h0;
   assign mem.mem_error  = memError;

   lsu_align align (
      .addr(capResult[1:0]), .funct3(capFunct3), .rs2(capRs2), .rdata(mem.mem_rdata),
      .wstrb(wstrb), .wdata(wdata), .loadData(loadData)
   );

   // Input boundary register; frozen while an access is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         capResult <= '0; capRs2 <= '0; capFunct3 <= '0; capRegDest <= '0;
         capMemWrite <= 1'b0; capMemRead <= 1'b0; capRegWrite <= 1'b0;
         capMemToReg <= 1'b0; capRegDataSrc <= 1'b0; capPcSrc <= 1'b0;
      end else if (!stall) begin
         capResult <= in_result; capRs2 <= in_rs2_value; capFunct3 <= in_funct3; capRegDest <= in_RegDest;
         capMemWrite <= in_MemWrite; capMemRead <= in_MemRead; capRegWrite <= in_RegWrite;
         capMemToReg <= in_MemToReg; capRegDataSrc <= in_RegDataSrc; capPcSrc <= in_PCSrc;
      end
   end

   // Handshake FSM; writeback registers change together at capture (non-memory) or completion (memory)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE; waitCnt <= '0; memReq <= 1'b0; stall <= 1'b0; memError <= 1'b0;
         out_RegWrite <= 1'b0; out_MemToReg <= 1'b0; out_RegDataSrc <= 1'b0; out_PCSrc <= 1'b0;
         out_RegDest <= '0; out_alu_result <= '0; out_mem_data <= '0;
      end else begin
         memError <= 1'b0;
         if (state == REQ) begin
            if (mem.mem_ack || timeUp) begin
               state          <= DONE;
               memReq         <= 1'b0;
               stall          <= 1'b0;
               waitCnt        <= '0;
               memError       <= !mem.mem_ack;
               out_RegWrite   <= capRegWrite & mem.mem_ack;
               out_MemToReg   <= capMemToReg;
               out_RegDataSrc <= capRegDataSrc;
               out_PCSrc      <= capPcSrc;
               out_RegDest    <= capRegDest;
               out_alu_result <= capResult;
               out_mem_data   <= !mem.mem_ack ? '0 : isLoad ? loadData : out_mem_data;
            end else begin
               waitCnt <= waitCnt + 1'b1;
            end
         end else if ((in_MemRead || in_MemWrite) && !misalign) begin
            state  <= REQ;
            memReq <= 1'b1;
            stall  <= 1'b1;
         end else begin
            state          <= misalign ? DONE : IDLE;
            memError       <= misalign;
            out_RegWrite   <= in_RegWrite & ~misalign;
            out_MemToReg   <= in_MemToReg;
            out_RegDataSrc <= in_RegDataSrc;
            out_PCSrc      <= in_PCSrc;
            out_RegDest    <= in_RegDest;
            out_alu_result <= in_result;
            out_mem_data   <= misalign ? '0 : out_mem_data;
         end
      end
   end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized memory-stage bench against a word-array memory model
module tb_memory_access;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] in_result, in_rs2_value;
   logic [2:0]  in_funct3;
   logic        in_MemWrite, in_MemRead, in_RegWrite, in_MemToReg, in_RegDataSrc, in_PCSrc;
   logic [4:0]  in_RegDest;
   logic        stall, out_RegWrite, out_MemToReg, out_RegDataSrc, out_PCSrc;
   logic [4:0]  out_RegDest;
   logic [31:0] out_alu_result, out_mem_data;
   logic [31:0] memWords [16];
   logic [31:0] expMemData;
   int          total = 0, bad = 0;

   memory_access_if bus();

   memory_access dut (
      .clk(clk), .rst(rst), .in_result(in_result), .in_rs2_value(in_rs2_value), .in_funct3(in_funct3),
      .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_RegWrite(in_RegWrite),
      .in_MemToReg(in_MemToReg), .in_RegDataSrc(in_RegDataSrc), .in_PCSrc(in_PCSrc),
      .in_RegDest(in_RegDest), .stall(stall), .mem(bus), .out_RegWrite(out_RegWrite),
      .out_MemToReg(out_MemToReg), .out_RegDataSrc(out_RegDataSrc), .out_PCSrc(out_PCSrc),
      .out_RegDest(out_RegDest), .out_alu_result(out_alu_result), .out_mem_data(out_mem_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int sizeOf(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [31:0] extLoad(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
      int sz, sh;
      logic [31:0] mask, v;
      sz   = sizeOf(f3);
      sh   = sz == 4 ? 0 : sz == 2 ? int'(a[1]) * 16 : int'(a[1:0]) * 8;
      mask = sz == 4 ? 32'hFFFF_FFFF : sz == 2 ? 32'h0000_FFFF : 32'h0000_00FF;
      v    = (w >> sh) & mask;
      if (sz < 4 && !f3[2] && v[sz*8-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit misaligned(input logic [31:0] a, input logic [2:0] f3);
`ifdef MEM_MISALIGN_TRAP_EN
      return (a % sizeOf(f3)) != 0;
`else
      return (a & 32'h0) != 0;
`endif
   endfunction

   // ackDly: REQ cycle (0-based) in which ack is given; negative means never
   task automatic runOp(input logic [31:0] res, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic mw, input logic mr, input logic rw, input logic [4:0] rd, input int ackDly);
      logic [2:0]  ctl;
      logic [3:0]  strb;
      logic [31:0] wd, rdata;
      int          sz, n, idx;
      bit          tout, isMem;
      ctl   = 3'($urandom);
      sz    = sizeOf(f3);
      idx   = int'(res[5:2]);
      isMem = mw | mr;
      n     = 0;
      rdata = '0;
      strb  = sz == 4 ? 4'hF : sz == 2 ? (res[1] ? 4'hC : 4'h3) : 4'(1 << res[1:0]);
      wd    = sz == 4 ? rs2 : sz == 2 ? rs2[15:0] * 32'h0001_0001 : rs2[7:0] * 32'h0101_0101;
      @(negedge clk);
      in_result = res; in_rs2_value = rs2; in_funct3 = f3; in_MemWrite = mw; in_MemRead = mr;
      in_RegWrite = rw; {in_MemToReg, in_RegDataSrc, in_PCSrc} = ctl; in_RegDest = rd;
      bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
      @(posedge clk); #1;
      if (isMem && !misaligned(res, f3)) begin
         chk("req_start", {bus.mem_req, stall}, 2'b11);
         chk("addr", bus.mem_addr, {res[31:2], 2'b00});
         chk("we_strb", {bus.mem_we, bus.mem_wstrb}, {mw, mw ? strb : 4'h0});
         if (mw) chk("wdata", bus.mem_wdata, wd);
         while (bus.mem_req === 1'b1 && n < 40) begin
            @(negedge clk);
            chk("hold", {bus.mem_we, bus.mem_wstrb, bus.mem_addr}, {mw, mw ? strb : 4'h0, res[31:2], 2'b00});
            bus.mem_ack = (n == ackDly);
            rdata = memWords[idx];
            bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
            in_result = $urandom; in_rs2_value = $urandom; in_funct3 = ~f3; in_MemWrite = ~mw;
            in_MemRead = ~mr; in_RegWrite = ~rw; in_RegDest = ~rd;
            @(posedge clk); #1;
            n++;
         end
         tout = !(ackDly >= 0 && ackDly < 15);
         chk("stall_cycles", 64'(n), 64'(tout ? 15 : ackDly + 1));
         chk("err", bus.mem_error, tout);
         chk("req_end", {bus.mem_req, stall}, 2'b00);
         if (tout) expMemData = '0;
         else if (mw) begin
            for (int i = 0; i < 4; i++) if (strb[i]) memWords[idx][i*8 +: 8] = wd[i*8 +: 8];
         end else expMemData = extLoad(rdata, res, f3);
         chk("ctl", {out_RegWrite, out_MemToReg, out_RegDataSrc, out_PCSrc, out_RegDest}, {rw & !tout, ctl, rd});
      end else begin
         chk("nostall", {bus.mem_req, stall}, 2'b00);
         chk("err", bus.mem_error, isMem);
         if (isMem) expMemData = '0;
         chk("ctl", {out_RegWrite, out_MemToReg, out_RegDataSrc, out_PCSrc, out_RegDest}, {rw & !isMem, ctl, rd});
      end
      chk("alu", out_alu_result, res);
      chk("mdata", out_mem_data, expMemData);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      in_result = '0; in_rs2_value = '0; in_funct3 = '0; in_MemWrite = 0; in_MemRead = 0;
      in_RegWrite = 0; in_MemToReg = 0; in_RegDataSrc = 0; in_PCSrc = 0; in_RegDest = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0; expMemData = '0;
      for (int i = 0; i < 16; i++) memWords[i] = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {stall, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_error, out_RegWrite,
                      out_MemToReg, out_RegDataSrc, out_PCSrc, out_RegDest}, '0);
      chk("rst_data", {out_alu_result, out_mem_data}, '0);
      @(negedge clk) rst = 0;

      runOp(32'h1234, 32'h0, 3'b000, 0, 0, 1, 5'd5, 0);
      chk("nm_rd", out_RegDest, 5'd5);
      runOp(32'h103, 32'hAABB_CCDD, 3'b000, 1, 0, 0, 5'd1, 0);
      runOp(32'h100, 32'h0080_FF00, 3'b010, 1, 0, 0, 5'd0, 0);
      runOp(32'h102, 32'h0, 3'b000, 0, 1, 1, 5'd7, 0);
      chk("lb_const", out_mem_data, 32'hFFFF_FF80);
      runOp(32'h102, 32'h0, 3'b100, 0, 1, 1, 5'd8, 1);
      chk("lbu_const", out_mem_data, 32'h0000_0080);
      runOp(32'h102, 32'h0, 3'b101, 0, 1, 1, 5'd9, 0);
      chk("lhu_const", out_mem_data, 32'h0000_0080);
      runOp(32'h100, 32'h0, 3'b010, 0, 1, 1, 5'd10, 2);
      chk("lw_const", out_mem_data, 32'h0080_FF00);
      runOp(32'h108, 32'h0, 3'b010, 0, 1, 1, 5'd3, -1);
      runOp(32'h55, 32'h0, 3'b000, 0, 0, 1, 5'd4, 0);
      runOp(32'h104, 32'h1122_3344, 3'b011, 1, 1, 1, 5'd6, 0);
      runOp(32'h102, 32'h0, 3'b010, 0, 1, 1, 5'd11, 0);

      @(negedge clk);
      in_result = 32'h104; in_funct3 = 3'b010; in_MemRead = 1; in_MemWrite = 0; bus.mem_ack = 0;
      @(posedge clk); #1;
      chk("rst_pre", {bus.mem_req, stall}, 2'b11);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("rst_async", {bus.mem_req, stall, out_RegWrite}, 3'b000);
      chk("rst_alu", out_alu_result, 32'h0);
      expMemData = '0;
      @(negedge clk);
      rst = 0; in_MemRead = 0;

      for (int k = 0; k < 150; k++) begin
         logic mw, mr;
         mw = ($urandom % 3) == 0;
         mr = ($urandom % 2) == 0;
         runOp(32'h100 + $urandom_range(0, 63), $urandom, 3'($urandom), mw, mr, 1'($urandom),
               5'($urandom), ($urandom % 20 == 0) ? -1 : int'($urandom_range(0, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 5-stage RV32I core; sits directly downstream of the execute stage and upstream of writeback.
- Registers the execute-stage outputs (ALU result, rs2 value, control bits) on its input boundary.
- For loads and stores, runs a req/ack handshake with the data memory, building byte strobes and load sign/zero extension; non-memory ops pass through.
- Stalls the upstream pipeline while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles mem_req may stay unacknowledged before the access is aborted; 4-bit wait counter.
- ADDR_WIDTH, 32: width of mem_addr; the low ADDR_WIDTH bits of the ALU result are used.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_result  in  32  ALU result; effective address for load/store
- in_rs2_value  in  32  store data
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_MemWrite, in_MemRead, in_RegWrite, in_MemToReg, in_RegDataSrc, in_PCSrc  in  1 each  control from execute
- in_RegDest  in  5  destination register
- stall  out  1  high: upstream must hold its registers and inputs
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address (low two bits forced to 0)
- mem_wdata  out  32  store data replicated into lanes
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read word; valid when mem_ack=1
- mem_ack  in  1  access complete
- mem_error  out  1  one-cycle pulse on timeout (or misalign when the feature is on)
- out_RegWrite, out_MemToReg, out_RegDataSrc, out_PCSrc  out  1 each  registered control to writeback
- out_RegDest  out  5
- out_alu_result  out  32
- out_mem_data  out  32  extended load data

Behaviour:
- Reset: asynchronous and active-high. All out_* = 0, out_mem_data = 0, stall = 0, mem_req = 0, mem_we = 0, mem_wstrb = 0, mem_error = 0, state = IDLE, wait counter = 0.
- Capture: on each rising edge with stall=0, all in_* are registered. With stall=1 the registers hold.
- FSM states: IDLE, REQ, DONE.
  - IDLE: capturing an op with MemRead or MemWrite set moves to REQ; any other op stays in IDLE. Non-memory ops have a latency of one edge with no stall.
  - REQ: mem_req=1 and stall=1. mem_addr, mem_we, mem_wdata and mem_wstrb are stable for the whole state. The counter increments each edge.
  - REQ -> DONE on an edge with mem_ack=1. Loads latch extended data into out_mem_data.
  - DONE: stall=0 and mem_req=0. The next edge captures the next op, which may re-enter REQ immediately.
- Minimum memory op cost: one stall cycle (ack in the first REQ cycle).
- MemRead and MemWrite both set: treated as a write; the load is ignored.
- Write strobes: SB = 1 << addr[1:0]; SH = 0011 if addr[1]=0, else 1100; SW = 1111. wdata lanes: byte replicated ×4, half replicated ×2.
- Load extract: byte/half selected by addr[1:0]/addr[1]; sign-extended for B/H, zero-extended for BU/HU. The funct3 value 011 and values 11x behave as W.
- Timeout: counter reaching TIMEOUT_CYCLES in REQ forces DONE. mem_error pulses for one cycle, out_mem_data = 0, out_RegWrite = 0 for that op.
- mem_ack while mem_req=0: ignored.
- Reset mid-access: abandons the access immediately; mem_req drops asynchronously.
- Control outputs are updated together with data at DONE (memory ops) or at capture (non-memory ops), so writeback sees a consistent set.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, issues no request. mem_error pulses, the state goes straight to DONE, and out_RegWrite = 0.
- Undefined: misaligned accesses silently use the truncated alignment rules above.

Decomposition:
- Shared package/header: funct3 size encodings, FSM state localparams, wait-counter width.
- One sub-module, lsu_align: purely combinational. Computes wstrb/wdata from addr, funct3 and rs2; computes extended load data from rdata, addr and funct3.

Test Plan:
- Non-memory op: in_RegWrite=1, RegDest=5, result=0x1234 -> next edge out_RegDest=5, out_alu_result=0x1234, stall never asserted.
- SB at addr 0x103 with rs2=0xAABBCCDD -> mem_addr=0x100, mem_wstrb=1000, mem_wdata=0xDDDDDDDD; ack in cycle 1 gives exactly 1 stall cycle.
- LB at 0x102, rdata=0x0080FF00 -> out_mem_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00000080.
- mem_ack delayed 3 cycles on LW -> stall high for 3 cycles, upstream inputs held, then out_mem_data=rdata.
- No ack -> after 15 cycles: mem_error pulse, out_RegWrite=0, the FSM resumes and the next op proceeds.
- rst asserted in REQ -> mem_req=0 and stall=0 immediately. With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no mem_req, mem_error pulse.
